// File: rtl/cpu_seq.sv
// cpu_seq: instruction sequencer for a small 6502 core.
// Fetches the reset vector, then opcodes and operands over a req/ack byte
// bus, and drives the regfile write port plus the next program counter.
// Outputs are combinational from the current state and latched bytes so
// that next_pc can follow mem_ack in the same cycle.
module cpu_seq #(
    parameter logic [15:0] RESET_VEC = 16'hFFFC,
    parameter int unsigned MAX_WAIT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic [15:0] pc,
    input  logic [7:0]  acc_reg,
    input  logic [7:0]  x_reg,
    input  logic [7:0]  y_reg,
    output logic [15:0] next_pc,
    output logic [7:0]  alu_hold_reg,
    output logic        wr_enable,
    output logic [1:0]  reg_dest,
    output logic        flag_we,
    output logic        flag_n,
    output logic        flag_z,
    output logic        sync,
    output logic        halted,
    output logic        bus_err
);

    // Wait counter must hold values 0..MAX_WAIT-1.
    localparam int unsigned WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);
    localparam logic [WCW-1:0] WAIT_ZERO = WCW'(0);
    localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

    localparam logic [15:0] VEC_HI_ADDR = RESET_VEC + 16'd1;

    // Regfile destinations
    localparam logic [1:0] DEST_A = 2'd0;
    localparam logic [1:0] DEST_X = 2'd1;
    localparam logic [1:0] DEST_Y = 2'd2;

    // Supported opcodes
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_TAX     = 8'hAA;
    localparam logic [7:0] OP_TAY     = 8'hA8;
    localparam logic [7:0] OP_TXA     = 8'h8A;
    localparam logic [7:0] OP_TYA     = 8'h98;
    localparam logic [7:0] OP_INX     = 8'hE8;
    localparam logic [7:0] OP_INY     = 8'hC8;
    localparam logic [7:0] OP_DEX     = 8'hCA;
    localparam logic [7:0] OP_DEY     = 8'h88;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_JAM     = 8'h02;

    typedef enum logic [2:0] {
        ST_VEC_LO  = 3'd0,
        ST_VEC_HI  = 3'd1,
        ST_FETCH   = 3'd2,
        ST_OPND_LO = 3'd3,
        ST_OPND_HI = 3'd4,
        ST_EXEC    = 3'd5,
        ST_HALT    = 3'd6
    } state_e;

    // Result of the single execute cycle
    typedef struct packed {
        logic       wr;
        logic [1:0] dest;
        logic [7:0] data;
        logic       jump;
    } exec_t;

    state_e         state_q, state_d;
    logic [7:0]     opcode_q, opcode_d;
    logic [7:0]     lo_q, lo_d;
    logic [7:0]     hi_q, hi_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           bus_err_q, bus_err_d;
    exec_t          exec_s;

    // Decode an opcode needing an operand byte after the opcode.
    function automatic logic has_operand(input logic [7:0] op);
        logic r;
        case (op)
            OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_JMP_ABS: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    // Compute the regfile write (or jump) performed in the execute cycle.
    // Unlisted opcodes fall into the default arm and behave as NOP.
    function automatic exec_t exec_op(input logic [7:0] op,
                                      input logic [7:0] imm,
                                      input logic [7:0] a,
                                      input logic [7:0] x,
                                      input logic [7:0] y);
        exec_t r;
        r.wr   = 1'b0;
        r.dest = DEST_A;
        r.data = 8'h00;
        r.jump = 1'b0;
        case (op)
            OP_LDA_IMM: begin r.wr = 1'b1; r.dest = DEST_A; r.data = imm;        end
            OP_LDX_IMM: begin r.wr = 1'b1; r.dest = DEST_X; r.data = imm;        end
            OP_LDY_IMM: begin r.wr = 1'b1; r.dest = DEST_Y; r.data = imm;        end
            OP_TAX:     begin r.wr = 1'b1; r.dest = DEST_X; r.data = a;          end
            OP_TAY:     begin r.wr = 1'b1; r.dest = DEST_Y; r.data = a;          end
            OP_TXA:     begin r.wr = 1'b1; r.dest = DEST_A; r.data = x;          end
            OP_TYA:     begin r.wr = 1'b1; r.dest = DEST_A; r.data = y;          end
            OP_INX:     begin r.wr = 1'b1; r.dest = DEST_X; r.data = x + 8'd1;   end
            OP_INY:     begin r.wr = 1'b1; r.dest = DEST_Y; r.data = y + 8'd1;   end
            OP_DEX:     begin r.wr = 1'b1; r.dest = DEST_X; r.data = x - 8'd1;   end
            OP_DEY:     begin r.wr = 1'b1; r.dest = DEST_Y; r.data = y - 8'd1;   end
            OP_JMP_ABS: begin r.jump = 1'b1;                                     end
            default:    begin r.wr = 1'b0;                                       end
        endcase
        return r;
    endfunction

    // Execute-cycle result from latched opcode/operand and current registers.
    always_comb begin
        exec_s = exec_op(opcode_q, lo_q, acc_reg, x_reg, y_reg);
    end

    // Next-state, bus, regfile-port and timeout logic.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        wait_cnt_d   = wait_cnt_q;
        bus_err_d    = bus_err_q;
        mem_req      = 1'b0;
        mem_addr     = pc;
        next_pc      = pc;
        alu_hold_reg = 8'h00;
        wr_enable    = 1'b0;
        reg_dest     = DEST_A;
        flag_we      = 1'b0;
        sync         = 1'b0;
        halted       = 1'b0;

        case (state_q)
            ST_VEC_LO: begin
                mem_req  = 1'b1;
                mem_addr = RESET_VEC;
                if (mem_ack) begin
                    lo_d    = mem_rdata;
                    state_d = ST_VEC_HI;
                end else begin
                    state_d = ST_VEC_LO;
                end
            end
            ST_VEC_HI: begin
                mem_req  = 1'b1;
                mem_addr = VEC_HI_ADDR;
                if (mem_ack) begin
                    next_pc = {mem_rdata, lo_q};
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_VEC_HI;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                sync    = 1'b1;
                if (mem_ack) begin
                    opcode_d = mem_rdata;
                    next_pc  = pc + 16'd1;
                    if (mem_rdata == OP_JAM) begin
                        state_d = ST_HALT;
                    end else if (has_operand(mem_rdata)) begin
                        state_d = ST_OPND_LO;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_OPND_LO: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    lo_d    = mem_rdata;
                    next_pc = pc + 16'd1;
                    if (opcode_q == OP_JMP_ABS) begin
                        state_d = ST_OPND_HI;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_OPND_LO;
                end
            end
            ST_OPND_HI: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    hi_d    = mem_rdata;
                    next_pc = pc + 16'd1;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_OPND_HI;
                end
            end
            ST_EXEC: begin
                wr_enable    = exec_s.wr;
                flag_we      = exec_s.wr;
                reg_dest     = exec_s.dest;
                alu_hold_reg = exec_s.data;
                if (exec_s.jump) begin
                    next_pc = {hi_q, lo_q};
                end else begin
                    next_pc = pc;
                end
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted  = 1'b1;
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_VEC_LO;
            end
        endcase

        // Bus timeout: an ack arriving on the cycle that would hit the limit wins.
        if (mem_req) begin
            if (mem_ack) begin
                wait_cnt_d = WAIT_ZERO;
            end else if (wait_cnt_q >= WAIT_LAST) begin
                wait_cnt_d = WAIT_ZERO;
                bus_err_d  = 1'b1;
                state_d    = ST_HALT;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_ONE;
            end
        end else begin
            wait_cnt_d = WAIT_ZERO;
        end
    end

    // Flags follow the write data directly.
    always_comb begin
        flag_n  = alu_hold_reg[7];
        flag_z  = (alu_hold_reg == 8'h00);
        bus_err = bus_err_q;
    end

    // State and latched-byte registers; reset returns to the vector fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_VEC_LO;
            opcode_q   <= 8'h00;
            lo_q       <= 8'h00;
            hi_q       <= 8'h00;
            wait_cnt_q <= WAIT_ZERO;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq: a byte memory with programmable ack delay and
// a small regfile model (pc <= next_pc, A/X/Y written on wr_enable).
module tb_cpu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] pc_r = 16'h0000;
    logic [7:0]  a_r = 8'h00;
    logic [7:0]  x_r = 8'h00;
    logic [7:0]  y_r = 8'h00;
    logic [15:0] next_pc;
    logic [7:0]  alu_hold_reg;
    logic        wr_enable;
    logic [1:0]  reg_dest;
    logic        flag_we;
    logic        flag_n;
    logic        flag_z;
    logic        sync;
    logic        halted;
    logic        bus_err;

    logic [7:0]  mem [0:65535];
    int          ack_delay = 0;
    logic        withhold = 1'b0;
    int          busy_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    cpu_seq #(.RESET_VEC(16'hFFFC), .MAX_WAIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pc(pc_r), .acc_reg(a_r), .x_reg(x_r), .y_reg(y_r),
        .next_pc(next_pc), .alu_hold_reg(alu_hold_reg), .wr_enable(wr_enable),
        .reg_dest(reg_dest), .flag_we(flag_we), .flag_n(flag_n), .flag_z(flag_z),
        .sync(sync), .halted(halted), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Memory responder: decides ack/data on the falling edge for the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack  = 1'b0;
            busy_cnt = 0;
        end else if (mem_req) begin
            if (!withhold && busy_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                busy_cnt  = 0;
            end else begin
                mem_ack  = 1'b0;
                busy_cnt = busy_cnt + 1;
            end
        end else begin
            mem_ack  = 1'b0;
            busy_cnt = 0;
        end
    end

    // Regfile model: pc loads next_pc every clock, registers on wr_enable.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_r <= 16'h0000;
        else        pc_r <= next_pc;
    end

    always @(posedge clk) begin
        if (wr_enable) begin
            case (reg_dest)
                2'd0:    a_r <= alu_hold_reg;
                2'd1:    x_r <= alu_hold_reg;
                2'd2:    y_r <= alu_hold_reg;
                default: a_r <= a_r;
            endcase
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (mem_addr !== 16'hFFFC) begin failures++; $display("FAIL rst_addr: got %h want %h", mem_addr, 16'hFFFC); end
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_req: got %b want 1", mem_req); end
        checks++; if ({wr_enable, flag_we, sync, halted, bus_err} !== 5'b00000) begin failures++; $display("FAIL rst_strobes: got %b want 00000", {wr_enable, flag_we, sync, halted, bus_err}); end
        checks++; if (next_pc !== 16'h0000) begin failures++; $display("FAIL rst_next_pc: got %h want 0000", next_pc); end
        release_reset();
    endtask

    task automatic test_vector();
        checks++; if (mem_addr !== 16'hFFFC || next_pc !== 16'h0000) begin failures++; $display("FAIL vec_lo: got addr %h npc %h want FFFC 0000", mem_addr, next_pc); end
        tick();
        checks++; if (mem_addr !== 16'hFFFD || next_pc !== 16'h8000) begin failures++; $display("FAIL vec_hi: got addr %h npc %h want FFFD 8000", mem_addr, next_pc); end
        tick();
        checks++; if (sync !== 1'b1 || mem_addr !== 16'h8000 || pc_r !== 16'h8000) begin failures++; $display("FAIL first_fetch: got sync %b addr %h pc %h want 1 8000 8000", sync, mem_addr, pc_r); end
    endtask

    task automatic test_lda();
        checks++; if (next_pc !== 16'h8001) begin failures++; $display("FAIL lda_fetch_npc: got %h want 8001", next_pc); end
        tick();
        checks++; if (mem_addr !== 16'h8001 || sync !== 1'b0 || wr_enable !== 1'b0) begin failures++; $display("FAIL lda_opnd: got addr %h sync %b wr %b want 8001 0 0", mem_addr, sync, wr_enable); end
        tick();
        checks++; if ({wr_enable, flag_we, reg_dest, alu_hold_reg, flag_n, flag_z} !== {1'b1, 1'b1, 2'd0, 8'h80, 1'b1, 1'b0}) begin failures++; $display("FAIL lda_exec: got wr %b fwe %b dest %0d data %h n %b z %b want 1 1 0 80 1 0", wr_enable, flag_we, reg_dest, alu_hold_reg, flag_n, flag_z); end
        checks++; if (next_pc !== 16'h8002 || mem_req !== 1'b0) begin failures++; $display("FAIL lda_exec_pc: got npc %h req %b want 8002 0", next_pc, mem_req); end
        tick();
        checks++; if (sync !== 1'b1 || pc_r !== 16'h8002 || a_r !== 8'h80) begin failures++; $display("FAIL lda_done: got sync %b pc %h A %h want 1 8002 80", sync, pc_r, a_r); end
    endtask

    task automatic test_ldx_inx_txa();
        tick();
        tick();
        checks++; if ({wr_enable, reg_dest, alu_hold_reg} !== {1'b1, 2'd1, 8'hFF}) begin failures++; $display("FAIL ldx_exec: got wr %b dest %0d data %h want 1 1 FF", wr_enable, reg_dest, alu_hold_reg); end
        tick();
        checks++; if (sync !== 1'b1 || pc_r !== 16'h8004) begin failures++; $display("FAIL inx_fetch: got sync %b pc %h want 1 8004", sync, pc_r); end
        tick();
        checks++; if ({wr_enable, reg_dest, alu_hold_reg, flag_n, flag_z} !== {1'b1, 2'd1, 8'h00, 1'b0, 1'b1}) begin failures++; $display("FAIL inx_exec: got wr %b dest %0d data %h n %b z %b want 1 1 00 0 1", wr_enable, reg_dest, alu_hold_reg, flag_n, flag_z); end
        tick();
        checks++; if (sync !== 1'b1 || pc_r !== 16'h8005) begin failures++; $display("FAIL txa_fetch: got sync %b pc %h want 1 8005", sync, pc_r); end
        tick();
        checks++; if ({wr_enable, reg_dest, alu_hold_reg, flag_z} !== {1'b1, 2'd0, 8'h00, 1'b1}) begin failures++; $display("FAIL txa_exec: got wr %b dest %0d data %h z %b want 1 0 00 1", wr_enable, reg_dest, alu_hold_reg, flag_z); end
        tick();
        checks++; if (a_r !== 8'h00 || x_r !== 8'h00 || pc_r !== 16'h8006) begin failures++; $display("FAIL txa_done: got A %h X %h pc %h want 00 00 8006", a_r, x_r, pc_r); end
    endtask

    task automatic test_jmp();
        tick();
        tick();
        checks++; if (mem_addr !== 16'h8008 || next_pc !== 16'h8009 || wr_enable !== 1'b0) begin failures++; $display("FAIL jmp_opnd_hi: got addr %h npc %h wr %b want 8008 8009 0", mem_addr, next_pc, wr_enable); end
        tick();
        checks++; if (next_pc !== 16'h1234 || wr_enable !== 1'b0 || flag_we !== 1'b0) begin failures++; $display("FAIL jmp_exec: got npc %h wr %b fwe %b want 1234 0 0", next_pc, wr_enable, flag_we); end
        tick();
        checks++; if (sync !== 1'b1 || mem_addr !== 16'h1234) begin failures++; $display("FAIL jmp_target: got sync %b addr %h want 1 1234", sync, mem_addr); end
    endtask

    task automatic test_wait_states_and_jam();
        tick();
        checks++; if ({wr_enable, reg_dest, alu_hold_reg} !== {1'b1, 2'd2, 8'h01}) begin failures++; $display("FAIL iny_exec: got wr %b dest %0d data %h want 1 2 01", wr_enable, reg_dest, alu_hold_reg); end
        ack_delay = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h1235 || next_pc !== 16'h1235 || sync !== 1'b1) begin failures++; $display("FAIL stall_%0d: got req %b addr %h npc %h sync %b want 1 1235 1235 1", i, mem_req, mem_addr, next_pc, sync); end
        end
        tick();
        checks++; if (next_pc !== 16'h1236) begin failures++; $display("FAIL stall_ack: got npc %h want 1236", next_pc); end
        ack_delay = 0;
        tick();
        checks++; if ({wr_enable, reg_dest, alu_hold_reg, flag_n} !== {1'b1, 2'd1, 8'hFF, 1'b1}) begin failures++; $display("FAIL dex_exec: got wr %b dest %0d data %h n %b want 1 1 FF 1", wr_enable, reg_dest, alu_hold_reg, flag_n); end
        tick();
        tick();
        checks++; if ({wr_enable, reg_dest, alu_hold_reg, flag_z} !== {1'b1, 2'd2, 8'h00, 1'b1}) begin failures++; $display("FAIL tay_exec: got wr %b dest %0d data %h z %b want 1 2 00 1", wr_enable, reg_dest, alu_hold_reg, flag_z); end
        tick();
        tick();
        checks++; if (wr_enable !== 1'b0 || flag_we !== 1'b0 || next_pc !== 16'h1238) begin failures++; $display("FAIL nop_exec: got wr %b fwe %b npc %h want 0 0 1238", wr_enable, flag_we, next_pc); end
        tick();
        tick();
        checks++; if (wr_enable !== 1'b0 || next_pc !== 16'h1239) begin failures++; $display("FAIL unknown_exec: got wr %b npc %h want 0 1239", wr_enable, next_pc); end
        tick();
        checks++; if (next_pc !== 16'h123A) begin failures++; $display("FAIL jam_fetch: got npc %h want 123A", next_pc); end
        tick();
        tick();
        checks++; if ({halted, bus_err, mem_req, wr_enable} !== 4'b1000 || next_pc !== 16'h123A) begin failures++; $display("FAIL jam_halt: got halt %b err %b req %b wr %b npc %h want 1 0 0 0 123A", halted, bus_err, mem_req, wr_enable, next_pc); end
        checks++; if (x_r !== 8'hFF || y_r !== 8'h00) begin failures++; $display("FAIL regs_after_jam: got X %h Y %h want FF 00", x_r, y_r); end
    endtask

    task automatic test_reset_mid_op();
        mem[16'hFFFD] = 8'h90;
        rst_n = 1'b0;
        tick();
        release_reset();
        tick();
        tick();
        tick();
        checks++; if (mem_addr !== 16'h9001 || mem_req !== 1'b1) begin failures++; $display("FAIL ldy_opnd: got addr %h req %b want 9001 1", mem_addr, mem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({wr_enable, flag_we, sync} !== 3'b000 || mem_addr !== 16'hFFFC) begin failures++; $display("FAIL async_rst: got wr %b fwe %b sync %b addr %h want 0 0 0 FFFC", wr_enable, flag_we, sync, mem_addr); end
        tick();
        tick();
        checks++; if (y_r !== 8'h00) begin failures++; $display("FAIL y_unwritten: got %h want 00", y_r); end
        release_reset();
        checks++; if (mem_addr !== 16'hFFFC || y_r !== 8'h00) begin failures++; $display("FAIL refetch_vec: got addr %h Y %h want FFFC 00", mem_addr, y_r); end
        tick();
        tick();
        checks++; if (sync !== 1'b1 || mem_addr !== 16'h9000) begin failures++; $display("FAIL refetch_fetch: got sync %b addr %h want 1 9000", sync, mem_addr); end
        tick();
        tick();
        checks++; if ({wr_enable, reg_dest, alu_hold_reg} !== {1'b1, 2'd2, 8'h55}) begin failures++; $display("FAIL ldy_exec: got wr %b dest %0d data %h want 1 2 55", wr_enable, reg_dest, alu_hold_reg); end
        tick();
        checks++; if (y_r !== 8'h55 || pc_r !== 16'h9002) begin failures++; $display("FAIL ldy_done: got Y %h pc %h want 55 9002", y_r, pc_r); end
    endtask

    task automatic test_timeout();
        withhold = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h9003 || halted !== 1'b0 || bus_err !== 1'b0) begin failures++; $display("FAIL tmo_wait_%0d: got req %b addr %h halt %b err %b want 1 9003 0 0", i, mem_req, mem_addr, halted, bus_err); end
        end
        tick();
        checks++; if ({bus_err, halted, mem_req} !== 3'b110) begin failures++; $display("FAIL tmo_err: got err %b halt %b req %b want 1 1 0", bus_err, halted, mem_req); end
        withhold = 1'b0;
        tick();
        tick();
        checks++; if ({bus_err, halted, mem_req} !== 3'b110) begin failures++; $display("FAIL tmo_sticky: got err %b halt %b req %b want 1 1 0", bus_err, halted, mem_req); end
    endtask

    task automatic test_ack_boundary();
        ack_delay = 7;
        rst_n = 1'b0;
        tick();
        checks++; if (bus_err !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL err_cleared: got err %b halt %b want 0 0", bus_err, halted); end
        release_reset();
        for (int i = 0; i < 8; i++) begin
            checks++; if (mem_addr !== 16'hFFFC || mem_req !== 1'b1 || bus_err !== 1'b0) begin failures++; $display("FAIL bnd_wait_%0d: got addr %h req %b err %b want FFFC 1 0", i, mem_addr, mem_req, bus_err); end
            tick();
        end
        checks++; if (mem_addr !== 16'hFFFD || bus_err !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL bnd_ack_wins: got addr %h err %b halt %b want FFFD 0 0", mem_addr, bus_err, halted); end
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h80;
        mem[16'h8002] = 8'hA2; mem[16'h8003] = 8'hFF;
        mem[16'h8004] = 8'hE8; mem[16'h8005] = 8'h8A;
        mem[16'h8006] = 8'h4C; mem[16'h8007] = 8'h34; mem[16'h8008] = 8'h12;
        mem[16'h1234] = 8'hC8; mem[16'h1235] = 8'hCA; mem[16'h1236] = 8'hA8;
        mem[16'h1237] = 8'hEA; mem[16'h1238] = 8'h0F; mem[16'h1239] = 8'h02;
        mem[16'h9000] = 8'hA0; mem[16'h9001] = 8'h55;

        test_reset();
        test_vector();
        test_lda();
        test_ldx_inx_txa();
        test_jmp();
        test_wait_states_and_jam();
        test_reset_mid_op();
        test_timeout();
        test_ack_boundary();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
